mc_fft_sched: RTL
=================

# mc_fft_sched

Job scheduler for the Monte-Carlo convolution path that time-shares one 256-point FFT core between the forward transform of the input samples and the inverse transform of the spectral products. It sits between the top-level sample stream and the shared FFT core, the spectrum buffer, the delta memory and the multiplier. It drives load and capture strobes, buffer addresses, the FFT input mux select and the output-stage enable, and it flags protocol and timeout errors.

## Interface
- N, 256, transform length (power of two)
- AW, 8, address width, log2(N)
- TIMEOUT, 2047, max consecutive idle cycles while waiting on the FFT core
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  top-level sample (x, delta) present
- ld_we  output  1  write delta memory at ld_addr
- ld_addr  output  AW  load index
- fft_in_valid  output  1  sample valid to FFT core
- fft_sel  output  1  FFT input mux: 0 = top x input, 1 = product path (conjugated img)
- fft_out_valid  input  1  FFT core output beat
- buf_we  output  1  capture forward spectrum at buf_waddr
- buf_waddr  output  AW  capture index
- rd_en  output  1  read spectrum buffer and delta memory at rd_addr
- rd_addr  output  AW  product read index
- out_en  output  1  final conjugate/scale stage consumes the current FFT beat
- busy  output  1  state != IDLE
- done  output  1  one-cycle job-complete pulse
- err  output  1  sticky error
- err_code  output  2  01 = timeout, 10 = stray in_valid; first error wins

## Operation
- States: IDLE, LOAD, FWD, FEED, INV, DONE, ERR.
- IDLE/LOAD: ld_we = fft_in_valid = in_valid, fft_sel = 0. ld_addr increments per accepted beat. In_valid in IDLE accepts beat 0 and moves to LOAD. Gaps are allowed. After the Nth beat, go to FWD.
- Capture: buf_we = fft_out_valid in LOAD or FWD. buf_waddr increments per beat. When the Nth capture beat arrives, go to FEED (captures during LOAD are kept).
- FEED: rd_en high for exactly N consecutive cycles, rd_addr 0..N-1. fft_in_valid equals rd_en delayed 2 cycles (memory register plus product register), with fft_sel = 1. Go to INV on the cycle after the last delayed fft_in_valid (N+2 cycles in FEED).
- out_en = fft_out_valid in FEED or INV. After N out_en beats, go to DONE.
- DONE: done = 1 for one cycle, then IDLE. All counters clear to 0.
- Watchdog: in FWD and INV, count cycles without fft_out_valid and reset the count on each beat. When the count reaches TIMEOUT, go to ERR with err_code = 01.
- ERR: all strobes are 0, busy = 1, err = 1. The block leaves ERR only on rst.
- Stray in_valid (in FWD, FEED, INV or DONE) is ignored: no ld_we and no fft_in_valid. err is set with err_code = 10 if err_code is still 00. The job continues.
- Counters wrap naturally at N. Completion is decided from beat counts, not from wrap.

## Timing
- Reset: state = IDLE. All counters, addresses, err, err_code, done and the delay line are 0. All outputs are 0 while rst is high.
- ld_we, buf_we, out_en and the LOAD-phase fft_in_valid are combinational from their inputs, gated by registered state: zero-cycle pass-through.
- rd_en, rd_addr, fft_sel, done, busy, err and err_code are registered.
- Minimum job with continuous input and FFT latency L (first output beat L cycles after first input), where L ≥ N:
  - LOAD cycles 0..N-1.
  - Capture L..L+N-1.
  - FEED from L+N: rd_en L+N..L+2N-1, fft_in_valid L+N+2..L+2N+1.
  - INV out_en from L+N+2+L' (L' = FFT latency for the inverse pass) for N beats.
  - done on the cycle after the last out_en.
- Simultaneous Nth capture beat and fft_out_valid on the next cycle: the extra beat is not captured (state is already FEED), and out_en counts it.
- Asynchronous rst mid-job aborts immediately. No partial done.

## Test plan
- Continuous job, N=256, FFT model L=300: ld_we cycles 0-255; buf_we 300-555 with buf_waddr 0-255; rd_en 556-811; fft_in_valid with fft_sel=1 on 558-813; 256 out_en beats; single done pulse; err=0.
- Input with a 1-cycle gap every 4th beat: ld_addr covers 0-255 exactly once, FWD is entered only after beat 256, and capture and output behaviour is identical.
- FFT model never asserts fft_out_valid after LOAD, TIMEOUT=2047: ERR entered 2047 cycles after entering FWD, err=1, err_code=01, no done; only rst clears it.
- in_valid pulsed at FEED cycle 10: fft_in_valid pattern unchanged, err=1, err_code=10, job still completes with done.
- rst asserted during FEED at rd_addr=100: all outputs 0 in the same cycle. After release, a fresh job starts at ld_addr=0 and completes normally.
- Back-to-back jobs with in_valid rising the cycle after done: second job accepted from IDLE, no err, two done pulses total.

Source files
------------

// File: rtl/mc_fft_sched.sv
// mc_fft_sched: job scheduler that time-shares one N-point FFT core between the
// forward transform of the input samples and the inverse transform of the products.
module mc_fft_sched #(
  parameter int N       = 256,
  parameter int AW      = 8,
  parameter int TIMEOUT = 2047
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          ld_we,
  output logic [AW-1:0] ld_addr,
  output logic          fft_in_valid,
  output logic          fft_sel,
  input  logic          fft_out_valid,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          out_en,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FWD, S_FEED, S_INV, S_DONE, S_ERR
  } state_t;

  localparam int                WW        = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]     LAST_IDX  = AW'(N - 1);
  localparam logic [AW:0]       LAST_BEAT = (AW+1)'(N - 1);
  localparam logic [AW+1:0]     FEED_END  = (AW+2)'(N + 1);
  localparam logic [WW-1:0]     WD_LAST   = WW'(TIMEOUT - 1);
  localparam logic [1:0]        E_TIMEOUT = 2'b01;
  localparam logic [1:0]        E_STRAY   = 2'b10;

  state_t        state, state_d;
  logic [AW-1:0] ld_cnt, rd_cnt;
  logic [AW:0]   cap_cnt, out_cnt;   // extra MSB marks "all N beats seen"
  logic [AW+1:0] feed_cnt;
  logic [WW-1:0] wd_cnt;
  logic [1:0]    dly;                // memory register + product register
  logic          rd_q, sel_q, busy_q, done_q, err_q;
  logic [1:0]    code_q;

  logic in_load, in_cap, in_out, in_wd;
  logic stray, cap_full, out_full, feed_last, wd_hit, load_last;

  assign in_load = (state == S_IDLE) || (state == S_LOAD);
  assign in_cap  = (state == S_LOAD) || (state == S_FWD);
  assign in_out  = (state == S_FEED) || (state == S_INV);
  assign in_wd   = (state == S_FWD)  || (state == S_INV);

  // NOTE: pass-through strobes are also gated by rst so every output is 0 while
  // reset is held, even though the IDLE state itself would forward in_valid.
  assign ld_we        = !rst && in_load && in_valid;
  assign buf_we       = !rst && in_cap && fft_out_valid && !cap_cnt[AW];
  assign out_en       = !rst && in_out && fft_out_valid && !out_cnt[AW];
  assign fft_in_valid = ld_we || ((state == S_FEED) && dly[1]);

  assign stray     = in_valid && (state inside {S_FWD, S_FEED, S_INV, S_DONE});
  assign load_last = ld_we && (state == S_LOAD) && (ld_cnt == LAST_IDX);
  assign cap_full  = cap_cnt[AW] || (buf_we && (cap_cnt == LAST_BEAT));
  assign out_full  = out_cnt[AW] || (out_en && (out_cnt == LAST_BEAT));
  assign feed_last = (state == S_FEED) && (feed_cnt == FEED_END);
  assign wd_hit    = in_wd && !fft_out_valid && (wd_cnt == WD_LAST);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state;
    unique case (state)
      S_IDLE: if (in_valid) state_d = S_LOAD;
      S_LOAD: if (load_last) state_d = cap_full ? S_FEED : S_FWD;
      S_FWD: begin
        if (cap_full)    state_d = S_FEED;
        else if (wd_hit) state_d = S_ERR;
      end
      S_FEED: if (feed_last) state_d = out_full ? S_DONE : S_INV;
      S_INV: begin
        if (out_full)    state_d = S_DONE;
        else if (wd_hit) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ld_cnt   <= '0;
      cap_cnt  <= '0;
      out_cnt  <= '0;
      rd_cnt   <= '0;
      feed_cnt <= '0;
      wd_cnt   <= '0;
      dly      <= '0;
      rd_q     <= 1'b0;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      state <= state_d;

      if (ld_we)  ld_cnt  <= ld_cnt + 1'b1;
      if (buf_we) cap_cnt <= cap_cnt + 1'b1;
      if (out_en) out_cnt <= out_cnt + 1'b1;

      // Product read burst starts on the same edge that enters FEED.
      if ((state != S_FEED) && (state_d == S_FEED)) rd_q <= 1'b1;
      else if (rd_q && (rd_cnt == LAST_IDX))         rd_q <= 1'b0;
      if (rd_q) rd_cnt <= rd_cnt + 1'b1;
      dly      <= {dly[0], rd_q};
      feed_cnt <= (state == S_FEED) ? feed_cnt + 1'b1 : '0;

      wd_cnt <= (in_wd && !fft_out_valid) ? wd_cnt + 1'b1 : '0;

      if (state == S_DONE) begin
        ld_cnt  <= '0;
        cap_cnt <= '0;
        out_cnt <= '0;
        rd_cnt  <= '0;
      end

      sel_q  <= (state_d == S_FEED);
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_DONE);

      if ((state_d == S_ERR) || stray) err_q <= 1'b1;
      if (code_q == 2'b00) begin
        if ((state_d == S_ERR) && (state != S_ERR)) code_q <= E_TIMEOUT;
        else if (stray)                             code_q <= E_STRAY;
      end
    end
  end

  assign ld_addr   = ld_cnt;
  assign buf_waddr = cap_cnt[AW-1:0];
  assign rd_en     = rd_q;
  assign rd_addr   = rd_cnt;
  assign fft_sel   = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule
